// File: rtl/spi_physical_master.sv
// Byte-level SPI master PHY: shifts one byte out on MOSI while capturing MISO,
// with all four CPOL/CPHA modes, bit-order select, clock divider and optional inter-byte gap.
module spi_physical_master (
    input  logic        clk,
    input  logic        rst,
    input  logic        ena,
    input  logic        msb_first,
    input  logic        delay_byte,
    input  logic [7:0]  n_delay_byte,
    input  logic        cpol,
    input  logic        cpha,
    input  logic [23:0] clk_div,
    output logic        new_byte,
    output logic        system_idle,
    input  logic [7:0]  data_in,
    output logic [7:0]  data_out,
    output logic        spi_clk,
    output logic        spi_mosi,
    input  logic        spi_miso,
    output logic        spi_cs_n
);
    localparam int unsigned CntW   = 32;
    localparam int unsigned EdgeW  = 5;
    localparam int unsigned NEdges = 16;

    typedef enum logic [2:0] {
        S_IDLE, S_LEAD, S_SHIFT, S_DONE, S_END, S_GAP
    } state_t;

    state_t            state_q;
    logic [CntW-1:0]   cnt_q;
    logic [EdgeW-1:0]  edge_q;
    logic [7:0]        tx_q;
    logic [7:0]        rx_q;
    logic [7:0]        data_out_q;
    logic              spi_clk_q;
    logic              cs_n_q;
    logic              mosi_q;
    logic              new_byte_q;
    logic              idle_q;

    logic [23:0]       half;
    logic [CntW-1:0]   gap_len;
    logic              half_done;
    logic              gap_done;
    logic              gap_en;
    logic              load;
    logic [EdgeW-1:0]  edge_d;
    logic              sample_edge;
    logic [7:0]        tx_shift_d;
    logic [7:0]        rx_shift_d;
    logic              tx_bit;
    logic              next_bit;
    logic              first_bit;

    // Timing: half SCLK period (never zero) and gap length in clk cycles
    assign half      = (clk_div[23:1] == 23'd0) ? 24'd1 : {1'b0, clk_div[23:1]};
    assign gap_len   = CntW'(n_delay_byte) * CntW'(clk_div);
    assign half_done = (cnt_q == CntW'(half - 24'd1));
    assign gap_done  = ((cnt_q + CntW'(1)) >= gap_len);
    assign gap_en    = delay_byte && (n_delay_byte != 8'd0);

    // Edge bookkeeping: odd edges are leading; sampling edge depends on cpha
    assign edge_d      = edge_q + EdgeW'(1);
    assign sample_edge = edge_d[0] ^ cpha;

    assign tx_shift_d = msb_first ? {tx_q[6:0], 1'b0} : {1'b0, tx_q[7:1]};
    assign rx_shift_d = msb_first ? {rx_q[6:0], spi_miso} : {spi_miso, rx_q[7:1]};
    assign tx_bit     = msb_first ? tx_q[7] : tx_q[0];
    assign next_bit   = msb_first ? tx_q[6] : tx_q[1];
    assign first_bit  = msb_first ? data_in[7] : data_in[0];

    // A new byte is taken from IDLE, from END in a continuous frame, or at the end of a gap
    assign load = ena && ((state_q == S_IDLE) ||
                          ((state_q == S_END) && !gap_en) ||
                          ((state_q == S_GAP) && gap_done));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            edge_q     <= '0;
            tx_q       <= '0;
            rx_q       <= '0;
            data_out_q <= '0;
            spi_clk_q  <= cpol;
            cs_n_q     <= 1'b1;
            mosi_q     <= 1'b0;
            new_byte_q <= 1'b0;
            idle_q     <= 1'b1;
        end else begin
            new_byte_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    spi_clk_q <= cpol;
                    mosi_q    <= 1'b0;
                    cs_n_q    <= 1'b1;
                    idle_q    <= 1'b1;
                end
                S_LEAD, S_SHIFT: begin
                    if (!half_done) begin
                        cnt_q <= cnt_q + CntW'(1);
                    end else begin
                        cnt_q <= '0;
                        if (edge_q == EdgeW'(NEdges)) begin
                            state_q    <= S_DONE;
                            new_byte_q <= 1'b1;
                            data_out_q <= rx_q;
                        end else begin
                            state_q   <= S_SHIFT;
                            edge_q    <= edge_d;
                            spi_clk_q <= ~spi_clk_q;
                            if (sample_edge) begin
                                rx_q <= rx_shift_d;
                            end else if (cpha || (edge_d != EdgeW'(NEdges))) begin
                                mosi_q <= cpha ? tx_bit : next_bit;
                                tx_q   <= tx_shift_d;
                            end
                        end
                    end
                end
                S_DONE: begin
                    state_q <= S_END;
                end
                S_END: begin
                    if (!ena) begin
                        state_q <= S_IDLE;
                        cs_n_q  <= 1'b1;
                        idle_q  <= 1'b1;
                        mosi_q  <= 1'b0;
                    end else if (gap_en) begin
                        state_q   <= S_GAP;
                        cs_n_q    <= 1'b1;
                        mosi_q    <= 1'b0;
                        spi_clk_q <= cpol;
                        cnt_q     <= '0;
                    end
                end
                S_GAP: begin
                    spi_clk_q <= cpol;
                    mosi_q    <= 1'b0;
                    cs_n_q    <= 1'b1;
                    if (!gap_done) begin
                        cnt_q <= cnt_q + CntW'(1);
                    end else if (!ena) begin
                        state_q <= S_IDLE;
                        idle_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase

            if (load) begin
                state_q <= S_LEAD;
                tx_q    <= data_in;
                mosi_q  <= cpha ? 1'b0 : first_bit;
                cnt_q   <= '0;
                edge_q  <= '0;
                cs_n_q  <= 1'b0;
                idle_q  <= 1'b0;
            end
        end
    end

    assign new_byte    = new_byte_q;
    assign system_idle = idle_q;
    assign data_out    = data_out_q;
    assign spi_clk     = spi_clk_q;
    assign spi_mosi    = mosi_q;
    assign spi_cs_n    = cs_n_q;

endmodule

// File: tb/tb_spi_physical_master.sv
// Scoreboard bench for spi_physical_master: a behavioural SPI slave supplies MISO and
// records MOSI; a monitor checks every new_byte pulse against queued expectations.
module tb_spi_physical_master;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ena = 1'b0;
    logic        msb_first = 1'b1;
    logic        delay_byte = 1'b0;
    logic [7:0]  n_delay_byte = 8'd0;
    logic        cpol = 1'b0;
    logic        cpha = 1'b0;
    logic [23:0] clk_div = 24'd10;
    logic [7:0]  data_in = 8'd0;
    logic        spi_miso = 1'b0;
    logic        new_byte, system_idle, spi_clk, spi_mosi, spi_cs_n;
    logic [7:0]  data_out;

    spi_physical_master dut (
        .clk(clk), .rst(rst), .ena(ena), .msb_first(msb_first),
        .delay_byte(delay_byte), .n_delay_byte(n_delay_byte),
        .cpol(cpol), .cpha(cpha), .clk_div(clk_div),
        .new_byte(new_byte), .system_idle(system_idle),
        .data_in(data_in), .data_out(data_out),
        .spi_clk(spi_clk), .spi_mosi(spi_mosi), .spi_miso(spi_miso), .spi_cs_n(spi_cs_n)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    typedef struct packed {
        logic [7:0] mosi_byte;
        logic [7:0] miso_byte;
    } exp_t;

    exp_t       sb_q[$];
    logic [7:0] slave_tx_q[$];
    logic [7:0] slave_rx_q[$];
    logic [7:0] tx_list[$];
    logic [7:0] rx_list[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Behavioural SPI slave: shifts its byte out on the drive edges, collects MOSI on sample edges
    logic       s_last_clk = 1'b0;
    int         s_edges = 0;
    bit         s_loaded = 1'b0;
    logic [7:0] s_tx = 8'd0;
    logic [7:0] s_rx = 8'd0;

    function automatic void s_drive();
        spi_miso = msb_first ? s_tx[7] : s_tx[0];
        s_tx     = msb_first ? (s_tx << 1) : (s_tx >> 1);
    endfunction

    function automatic void s_load();
        s_tx     = (slave_tx_q.size() > 0) ? slave_tx_q.pop_front() : 8'd0;
        s_rx     = 8'd0;
        s_loaded = 1'b1;
        if (cpha == 1'b0) s_drive();
    endfunction

    function automatic void s_edge();
        bit lead;
        bit sample_here;
        s_edges++;
        lead        = (s_edges % 2) == 1;
        sample_here = (cpha == 1'b0) ? lead : !lead;
        if (sample_here)
            s_rx = msb_first ? {s_rx[6:0], spi_mosi} : {spi_mosi, s_rx[7:1]};
        else if (cpha == 1'b1 || s_edges != 16)
            s_drive();
        if (s_edges == 16) begin
            slave_rx_q.push_back(s_rx);
            s_edges  = 0;
            s_loaded = 1'b0;
            if (slave_tx_q.size() > 0) s_load();
        end
    endfunction

    always @(spi_clk or spi_cs_n or rst) begin
        if (rst) begin
            s_edges  = 0;
            s_loaded = 1'b0;
        end else if (spi_cs_n === 1'b0) begin
            if (!s_loaded) s_load();
            else if (spi_clk !== s_last_clk) s_edge();
        end
        s_last_clk = spi_clk;
    end

    // Monitor: every new_byte pulse pops one expectation
    logic nb_prev = 1'b0;
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            nb_prev = 1'b0;
        end else begin
            if (new_byte) begin
                chk("new_byte_width", 32'(nb_prev), 32'd0);
                if (sb_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_new_byte: got pulse expected none (t=%0t)", $time);
                end else begin
                    e = sb_q.pop_front();
                    chk("data_out", 32'(data_out), 32'(e.miso_byte));
                    if (slave_rx_q.size() == 0) begin
                        tests++;
                        fails++;
                        $display("FAIL slave_rx: got nothing expected %0h", e.mosi_byte);
                    end else begin
                        chk("slave_rx", 32'(slave_rx_q.pop_front()), 32'(e.mosi_byte));
                    end
                end
            end
            nb_prev = new_byte;
        end
    end

    // SCLK edge spacing within a byte must equal the half period
    logic sclk_prev = 1'b0;
    int   cyc = 0;
    int   eidx = 0;
    always @(negedge clk) begin
        int exp_h;
        exp_h = (clk_div / 2 == 0) ? 1 : int'(clk_div / 2);
        cyc++;
        if (rst) begin
            eidx = 0;
            cyc  = 0;
        end else if (spi_cs_n == 1'b0 && spi_clk !== sclk_prev) begin
            if (eidx > 0) chk("sclk_half_period", 32'(cyc), 32'(exp_h));
            eidx = (eidx == 15) ? 0 : eidx + 1;
            cyc  = 0;
        end
        sclk_prev = spi_clk;
    end

    // Send tx_list while the slave answers rx_list; checks gap time and idle state afterwards
    task automatic run_bytes(input string name, input int exp_cs_hi);
        int n;
        int got;
        int cs_hi;
        int guard;
        n     = tx_list.size();
        got   = 0;
        cs_hi = 0;
        guard = 0;
        for (int i = 0; i < n; i++) begin
            sb_q.push_back('{mosi_byte: tx_list[i], miso_byte: rx_list[i]});
            slave_tx_q.push_back(rx_list[i]);
        end
        @(negedge clk);
        data_in = tx_list[0];
        ena     = 1'b1;
        while (got < n && guard < 20000) begin
            @(negedge clk);
            guard++;
            if (got > 0 && spi_cs_n) cs_hi++;
            if (new_byte) begin
                got++;
                if (got < n) data_in = tx_list[got];
                else ena = 1'b0;
            end
        end
        if (got < n) begin
            tests++;
            fails++;
            $display("FAIL %s_timeout: got %0d bytes expected %0d", name, got, n);
            ena = 1'b0;
        end
        guard = 0;
        while (!system_idle && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        @(negedge clk);
        chk({name, "_idle"}, 32'(system_idle), 32'd1);
        chk({name, "_sclk_idle"}, 32'(spi_clk), 32'(cpol));
        chk({name, "_cs_n"}, 32'(spi_cs_n), 32'd1);
        chk({name, "_mosi"}, 32'(spi_mosi), 32'd0);
        chk({name, "_cs_high_cycles"}, 32'(cs_hi), 32'(exp_cs_hi));
        chk({name, "_sb_empty"}, 32'(sb_q.size()), 32'd0);
    endtask

    task automatic set_cfg(input logic pol, input logic pha, input logic msb,
                           input logic [23:0] div, input logic dly, input logic [7:0] ndly);
        @(negedge clk);
        cpol = pol; cpha = pha; msb_first = msb;
        clk_div = div; delay_byte = dly; n_delay_byte = ndly;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        #800000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int nb;
        int exp_gap;
        repeat (3) @(negedge clk);
        chk("rst_cs_n", 32'(spi_cs_n), 32'd1);
        chk("rst_sclk", 32'(spi_clk), 32'(cpol));
        chk("rst_mosi", 32'(spi_mosi), 32'd0);
        chk("rst_new_byte", 32'(new_byte), 32'd0);
        chk("rst_idle", 32'(system_idle), 32'd1);
        chk("rst_data_out", 32'(data_out), 32'd0);
        rst = 1'b0;

        set_cfg(1'b0, 1'b0, 1'b1, 24'd10, 1'b1, 8'd5);
        tx_list = '{8'hE5}; rx_list = '{8'h3D};
        run_bytes("mode0_msb", 0);

        set_cfg(1'b0, 1'b0, 1'b0, 24'd10, 1'b1, 8'd5);
        run_bytes("mode0_lsb", 0);
        set_cfg(1'b1, 1'b0, 1'b1, 24'd10, 1'b1, 8'd5);
        run_bytes("cpol1", 0);
        set_cfg(1'b1, 1'b1, 1'b1, 24'd10, 1'b1, 8'd5);
        run_bytes("cpol1_cpha1", 0);

        set_cfg(1'b0, 1'b1, 1'b1, 24'd10, 1'b1, 8'd5);
        tx_list = '{8'hE5, 8'hA3, 8'h7F, 8'h00, 8'hFF, 8'h12, 8'h34, 8'h56, 8'h78, 8'h9A};
        rx_list = '{8'h3D, 8'hC7, 8'h81, 8'h00, 8'hFF, 8'hAB, 8'hCD, 8'hEF, 8'h01, 8'h23};
        run_bytes("burst10_gap", 9 * 5 * 10);

        set_cfg(1'b0, 1'b0, 1'b1, 24'd10, 1'b0, 8'd5);
        tx_list = '{8'h5A, 8'hC3}; rx_list = '{8'h96, 8'h0F};
        run_bytes("continuous2", 0);

        // Reset in the middle of SHIFT aborts without a new_byte pulse
        set_cfg(1'b1, 1'b0, 1'b1, 24'd10, 1'b0, 8'd0);
        slave_tx_q.push_back(8'h77);
        @(negedge clk);
        data_in = 8'hA5;
        ena     = 1'b1;
        repeat (30) @(negedge clk);
        chk("pre_rst_busy", 32'(system_idle), 32'd0);
        rst = 1'b1;
        ena = 1'b0;
        @(negedge clk);
        chk("midrst_cs_n", 32'(spi_cs_n), 32'd1);
        chk("midrst_sclk", 32'(spi_clk), 32'(cpol));
        chk("midrst_idle", 32'(system_idle), 32'd1);
        chk("midrst_new_byte", 32'(new_byte), 32'd0);
        chk("midrst_data_out", 32'(data_out), 32'd0);
        chk("midrst_mosi", 32'(spi_mosi), 32'd0);
        rst = 1'b0;
        slave_tx_q.delete();
        slave_rx_q.delete();
        repeat (100) @(negedge clk);
        chk("post_rst_idle", 32'(system_idle), 32'd1);

        // Randomised configurations and payloads
        for (int r = 0; r < 10; r++) begin
            set_cfg(1'($urandom), 1'($urandom), 1'($urandom), 24'($urandom_range(1, 13)),
                    1'($urandom), 8'($urandom_range(0, 4)));
            nb = $urandom_range(1, 4);
            tx_list.delete();
            rx_list.delete();
            for (int i = 0; i < nb; i++) begin
                tx_list.push_back(8'($urandom));
                rx_list.push_back(8'($urandom));
            end
            exp_gap = (delay_byte && n_delay_byte != 0) ?
                      (nb - 1) * int'(n_delay_byte) * int'(clk_div) : 0;
            run_bytes("random", exp_gap);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/spi_physical_master.md
Name: spi_physical_master

Overview:
- Byte-level SPI master physical layer: serialises one 8-bit word per transfer on MOSI and deserialises MISO simultaneously.
- Generates SCLK and an active-low chip select.
- Supports all four CPOL/CPHA modes, MSB/LSB-first ordering, a programmable clock divider and an optional inter-byte gap.
- Sits below a register/AXI front end that drives `ena`/`data_in` and consumes `new_byte`/`data_out`.

Parameters:
- None. All configuration arrives on ports.

Ports:
- clk  in  1  system clock; all logic on the rising edge
- rst  in  1  reset, synchronous, active-high
- ena  in  1  request transfers; held high for back-to-back bytes
- msb_first  in  1  1 = bit 7 first, 0 = bit 0 first
- delay_byte  in  1  1 = insert an inter-byte gap
- n_delay_byte  in  8  gap length in SCLK periods
- cpol  in  1  SCLK idle level
- cpha  in  1  0 = sample on leading edge, 1 = sample on trailing edge
- clk_div  in  24  SCLK period in clk cycles
- new_byte  out  1  one-cycle pulse: byte complete, `data_out` valid
- system_idle  out  1  high while in IDLE
- data_in  in  8  byte to transmit
- data_out  out  8  last received byte
- spi_clk  out  1  SCLK
- spi_mosi  out  1  MOSI
- spi_miso  in  1  MISO; sampled as-is
- spi_cs_n  out  1  chip select, active low

Behaviour:
- Clock/reset: one clock. Reset is synchronous and active-high. The clock and reset ports are named `clk` and `rst`.
- Reset values:
  - `spi_clk` = `cpol`
  - `spi_cs_n` = 1, `spi_mosi` = 0
  - `new_byte` = 0, `system_idle` = 1, `data_out` = 0
  - FSM in IDLE, counters and shift registers cleared
- Reset mid-transfer aborts immediately to the reset state.
- Half-period H = `clk_div`>>1; if H = 0, use H = 1. For example, `clk_div` = 10 gives 5 clk cycles per SCLK phase, i.e. 10 MHz from 100 MHz.
- Configuration inputs are read live. They must be stable while `system_idle` = 0. `spi_clk` follows `cpol` whenever not transferring.
- FSM states: IDLE, LEAD, SHIFT, DONE, END, GAP.
  - IDLE: `cs_n` = 1, `system_idle` = 1. When `ena` = 1: latch `data_in` into the TX shift register, `cs_n` <= 0, go to LEAD.
  - LEAD: H cycles with SCLK at idle level. For `cpha` = 0, MOSI already carries the first bit (bit 7 if `msb_first`, else bit 0). Then go to SHIFT.
  - SHIFT: 16 SCLK edges, one every H cycles.
    - `cpha` = 0: sample MISO on each leading edge; shift MOSI to the next bit on each trailing edge except the last.
    - `cpha` = 1: drive the next MOSI bit on each leading edge (first bit on the first leading edge); sample MISO on each trailing edge.
    - Received bits are assembled in the same order as `msb_first`.
    - After the 16th edge (SCLK back at idle), hold H cycles, then go to DONE.
  - DONE: one cycle. `new_byte` = 1; `data_out` <= received byte in the same cycle. `cs_n` stays low. Go to END.
  - END: one cycle. `ena` is evaluated here, one clock after the `new_byte` pulse.
    - `ena` = 0: go to IDLE, `cs_n` = 1.
    - `ena` = 1 and (`delay_byte` = 0 or `n_delay_byte` = 0): latch `data_in`, go to LEAD with `cs_n` held low (continuous frame).
    - `ena` = 1 and `delay_byte` = 1: go to GAP.
  - GAP: `cs_n` = 1, SCLK idle, for `n_delay_byte`×`clk_div` cycles. Then: `ena` = 1 → latch `data_in`, `cs_n` <= 0, go to LEAD; otherwise go to IDLE.
- `data_out` holds its value until the next DONE.
- `new_byte` is exactly one cycle wide per byte.
- Dropping `ena` mid-byte does not abort: the byte completes, then the block returns to IDLE.
- `spi_mosi` = 0 in IDLE and GAP.

Test Plan:
- Mode 0, MSB-first, `clk_div` = 10, `delay_byte` = 1, `n_delay_byte` = 5; master sends 0xE5 → slave sampling on leading edges receives 0xE5; SCLK period is 10 clk cycles; one `new_byte` pulse; `system_idle` returns to 1.
- Same configuration, slave returns 0x3D on MISO → `data_out` = 0x3D at the `new_byte` pulse.
- LSB-first, then CPOL = 1, then CPOL = 1/CPHA = 1: repeat 0xE5 TX / 0x3D RX → both directions match in every mode; SCLK idles at `cpol`.
- CPHA = 1, `ena` held across 10 bytes (TX E5, A3, 7F, 00, FF, 12, 34, 56, 78, 9A; RX 3D, C7, 81, 00, FF, AB, CD, EF, 01, 23) → all 20 bytes match; `cs_n` high for 50 clk cycles between bytes.
- `delay_byte` = 0, `ena` held for 2 bytes → `cs_n` stays low across the byte boundary; two `new_byte` pulses.
- Assert `rst` in the middle of SHIFT → next cycle `cs_n` = 1, `spi_clk` = `cpol`, `system_idle` = 1, no `new_byte` pulse.
